// File: rtl/hshift_pkg.sv
// Shared types and default constants for the horizontal shift controller.
package hshift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD_DLY = 2'd1,
    ST_REPEAT   = 2'd2
  } state_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam int DEF_X_W         = 12;
  localparam int DEF_STEP        = 25;
  localparam int DEF_MAX_STEPS   = 11;
  localparam int DEF_REPEAT_DLY  = 8;
  localparam int DEF_REPEAT_RATE = 2;

endpackage

// File: rtl/hshift_repeat_timer.sv
// Tick-driven down-counter: load wins over decrement; done marks the tick
// that brings the count to zero.
module hshift_repeat_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: load has priority, decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  assign done = dec && (cnt_q <= CNT_W'(1));

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hshift_ctrl.sv
// Horizontal shift controller: button press steps the offset immediately,
// holding the button auto-repeats after a tick-counted delay.
//
//   state       | meaning
//   ST_IDLE     | waiting for a single clean press edge
//   ST_HOLD_DLY | button held, counting ticks before auto-repeat
//   ST_REPEAT   | auto-repeating one step every REPEAT_RATE ticks
module hshift_ctrl import hshift_pkg::*; #(
  parameter int X_W         = DEF_X_W,
  parameter int STEP        = DEF_STEP,
  parameter int MAX_STEPS   = DEF_MAX_STEPS,
  parameter int REPEAT_DLY  = DEF_REPEAT_DLY,
  parameter int REPEAT_RATE = DEF_REPEAT_RATE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  pause,
  input  logic                  center,
  input  logic                  left_btn,
  input  logic                  right_btn,
  output logic signed [X_W-1:0] pos_x,
  output logic                  face_right,
  output logic                  at_left_lim,
  output logic                  at_right_lim,
  output logic                  moving
);

  localparam int OFF_W   = $clog2(MAX_STEPS + 1) + 1;
  localparam int CNT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic signed [OFF_W-1:0] OFF_MAX = OFF_W'(MAX_STEPS);
  localparam logic signed [OFF_W-1:0] OFF_MIN = -OFF_MAX;

  // The largest offset must be representable in pos_x.
  if (STEP * MAX_STEPS > (2 ** (X_W - 1)) - 1) begin : g_bad_fit
    $error("hshift_ctrl: STEP*MAX_STEPS does not fit in signed X_W");
  end

  state_t                  state_q, state_d;
  dir_t                    dir_q, dir_d, step_dir;
  logic signed [OFF_W-1:0] off_q, off_d;
  logic                    face_q, face_d;
  logic                    left_q, right_q;
  logic                    rise_l, rise_r, dir_btn, other_btn, step_en;
  logic                    tmr_load, tmr_dec, tmr_done;
  logic [CNT_W-1:0]        tmr_val;

  assign rise_l    = left_btn & ~left_q;
  assign rise_r    = right_btn & ~right_q;
  assign dir_btn   = (dir_q == DIR_LEFT) ? left_btn : right_btn;
  assign other_btn = (dir_q == DIR_LEFT) ? right_btn : left_btn;

  // Next state, direction, facing and offset; center outranks pause and steps.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    face_d   = face_q;
    off_d    = off_q;
    step_en  = 1'b0;
    step_dir = dir_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    if (center) begin
      off_d    = '0;
      state_d  = ST_IDLE;
      tmr_load = 1'b1;
    end else if (!pause) begin
      case (state_q)
        ST_IDLE: begin
          if (rise_l && !right_btn) begin
            step_en  = 1'b1;
            step_dir = DIR_LEFT;
            dir_d    = DIR_LEFT;
            face_d   = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(REPEAT_DLY);
            state_d  = ST_HOLD_DLY;
          end else if (rise_r && !left_btn) begin
            step_en  = 1'b1;
            step_dir = DIR_RIGHT;
            dir_d    = DIR_RIGHT;
            face_d   = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(REPEAT_DLY);
            state_d  = ST_HOLD_DLY;
          end
        end
        ST_HOLD_DLY, ST_REPEAT: begin
          if (!dir_btn || other_btn) begin
            state_d = ST_IDLE;
          end else if (tick) begin
            tmr_dec = 1'b1;
            if (tmr_done) begin
              step_en  = 1'b1;
              tmr_load = 1'b1;
              tmr_val  = CNT_W'(REPEAT_RATE);
              state_d  = ST_REPEAT;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Steps past the limit are dropped; sequencing carries on regardless.
    if (step_en) begin
      if (step_dir == DIR_LEFT && off_q != OFF_MAX) begin
        off_d = off_q + OFF_W'(1);
      end else if (step_dir == DIR_RIGHT && off_q != OFF_MIN) begin
        off_d = off_q - OFF_W'(1);
      end
    end
  end

  hshift_repeat_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .done     (tmr_done)
  );

  // Control registers; button history samples every cycle, even when paused.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_LEFT;
      face_q  <= 1'b1;
      off_q   <= '0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      face_q  <= face_d;
      off_q   <= off_d;
      left_q  <= left_btn;
      right_q <= right_btn;
    end
  end

  assign pos_x        = X_W'(STEP * off_q);
  assign face_right   = face_q;
  assign at_left_lim  = (off_q == OFF_MAX);
  assign at_right_lim = (off_q == OFF_MIN);
  assign moving       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hshift_ctrl.sv
// Directed and random checks of hshift_ctrl against a hold-time based model.
module tb_hshift_ctrl;

  localparam int X_W   = 12;
  localparam int STEP  = 25;
  localparam int MAXS  = 11;
  localparam int DLY   = 8;
  localparam int RATE  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1, tick = 1'b0, pause = 1'b0, center = 1'b0;
  logic left_btn = 1'b0, right_btn = 1'b0;
  logic signed [X_W-1:0] pos_x;
  logic face_right, at_left_lim, at_right_lim, moving;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: offset, facing, whether a press is active, its direction and
  // how many ticks it has been held.
  int m_off = 0, m_face = 1, m_active = 0, m_dir = 1, m_held = 0;
  int m_pl = 0, m_pr = 0;

  always #5 clk = ~clk;

  hshift_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .pause        (pause),
    .center       (center),
    .left_btn     (left_btn),
    .right_btn    (right_btn),
    .pos_x        (pos_x),
    .face_right   (face_right),
    .at_left_lim  (at_left_lim),
    .at_right_lim (at_right_lim),
    .moving       (moving)
  );

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic void m_step(input int d);
    if (m_off + d <= MAXS && m_off + d >= -MAXS) m_off = m_off + d;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic m_update();
    int rl, rr, l, r, own, oth;
    l = int'(left_btn);
    r = int'(right_btn);
    if (rst) begin
      m_off = 0; m_face = 1; m_active = 0; m_held = 0; m_pl = 0; m_pr = 0;
      return;
    end
    rl = l & ~m_pl;
    rr = r & ~m_pr;
    m_pl = l;
    m_pr = r;
    if (center) begin
      m_off = 0; m_active = 0; m_held = 0;
    end else if (!pause) begin
      if (!m_active) begin
        if (rl && !r) begin
          m_step(1); m_face = 0; m_dir = 1; m_active = 1; m_held = 0;
        end else if (rr && !l) begin
          m_step(-1); m_face = 1; m_dir = -1; m_active = 1; m_held = 0;
        end
      end else begin
        own = (m_dir > 0) ? l : r;
        oth = (m_dir > 0) ? r : l;
        if (!own || oth) m_active = 0;
        else if (tick) begin
          m_held++;
          if (m_held == DLY || (m_held > DLY && (m_held - DLY) % RATE == 0)) m_step(m_dir);
        end
      end
    end
  endtask

  task automatic check_model();
    chk("pos_x", pos_x, m_off * STEP);
    chk("face_right", face_right, m_face);
    chk("moving", moving, m_active);
    chk("at_left_lim", at_left_lim, (m_off == MAXS) ? 1 : 0);
    chk("at_right_lim", at_right_lim, (m_off == -MAXS) ? 1 : 0);
  endtask

  task automatic cyc();
    m_update();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
    end
    tick = 1'b0;
  endtask

  task automatic do_reset();
    left_btn = 1'b0; right_btn = 1'b0; tick = 1'b0; pause = 1'b0; center = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_pos", pos_x, 0);
    chk("rst_face", face_right, 1);
    chk("rst_moving", moving, 0);
    rst = 1'b0;
    cyc();

    // Single short left press
    left_btn = 1'b1;
    cyc();
    chk("tap_pos", pos_x, 25);
    chk("tap_face", face_right, 0);
    left_btn = 1'b0;
    cyc();
    chk("tap_idle", moving, 0);

    // Right held for 14 ticks
    do_reset();
    right_btn = 1'b1;
    cyc();
    ticks(7);
    chk("rhold_pre", pos_x, -25);
    ticks(7);
    chk("rhold_pos", pos_x, -125);
    chk("rhold_face", face_right, 1);
    right_btn = 1'b0;
    cyc();

    // Left held to the limit, then a fresh press at the limit
    do_reset();
    left_btn = 1'b1;
    cyc();
    ticks(40);
    chk("sat_pos", pos_x, 275);
    chk("sat_lim", at_left_lim, 1);
    left_btn = 1'b0;
    cyc();
    left_btn = 1'b1;
    cyc();
    chk("sat_press_pos", pos_x, 275);
    chk("sat_press_face", face_right, 0);
    left_btn = 1'b0;
    cyc();

    // Both buttons rising together, then opposite button during repeat
    do_reset();
    left_btn = 1'b1; right_btn = 1'b1;
    cyc();
    chk("both_pos", pos_x, 0);
    chk("both_face", face_right, 1);
    chk("both_moving", moving, 0);
    left_btn = 1'b0; right_btn = 1'b0;
    cyc();
    left_btn = 1'b1;
    cyc();
    ticks(10);
    chk("opp_pre", pos_x, 75);
    right_btn = 1'b1;
    cyc();
    chk("opp_moving", moving, 0);
    chk("opp_pos", pos_x, 75);
    left_btn = 1'b0; right_btn = 1'b0;
    cyc();

    // Pause during repeat keeps the partial count
    do_reset();
    left_btn = 1'b1;
    cyc();
    ticks(9);
    chk("pause_pre", pos_x, 50);
    pause = 1'b1;
    ticks(10);
    chk("pause_frozen", pos_x, 50);
    chk("pause_moving", moving, 1);
    pause = 1'b0;
    ticks(1);
    chk("pause_resume", pos_x, 75);
    left_btn = 1'b0;
    cyc();

    // Center at 150, then reset mid-repeat
    do_reset();
    left_btn = 1'b1;
    cyc();
    ticks(16);
    chk("ctr_pre", pos_x, 150);
    center = 1'b1;
    cyc();
    center = 1'b0;
    chk("ctr_pos", pos_x, 0);
    chk("ctr_face", face_right, 0);
    chk("ctr_moving", moving, 0);
    left_btn = 1'b0;
    cyc();
    left_btn = 1'b1;
    cyc();
    ticks(10);
    rst = 1'b1;
    cyc();
    chk("mrst_pos", pos_x, 0);
    chk("mrst_face", face_right, 1);
    chk("mrst_moving", moving, 0);
    rst = 1'b0;
    left_btn = 1'b0;
    cyc();

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) left_btn = ~left_btn;
      if ($urandom_range(0, 9) == 0) right_btn = ~right_btn;
      if ($urandom_range(0, 24) == 0) pause = ~pause;
      tick   = ($urandom_range(0, 2) == 0);
      center = ($urandom_range(0, 79) == 0);
      rst    = ($urandom_range(0, 399) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
